// File: rtl/lcd_pkg.sv
// Shared types and timing defaults for the lcd_0 panel interface.
package lcd_pkg;

  // Bus-writer sequencing states.
  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    IDLE,
    SETUP,
    WR_LOW,
    WR_HIGH
  } lcd_state_t;

  // Default strobe and panel-reset timing, in clk cycles (50 MHz).
  localparam int unsigned LCD_CS_SETUP_CYCLES  = 1;
  localparam int unsigned LCD_WR_LOW_CYCLES    = 2;
  localparam int unsigned LCD_WR_HIGH_CYCLES   = 2;
  localparam int unsigned LCD_RESX_LOW_CYCLES  = 500;
  localparam int unsigned LCD_RESX_WAIT_CYCLES = 6000000;

  // Delay counter width; 23 bits covers the 120 ms post-reset wait.
  localparam int unsigned CNT_W = 23;

  // Counter load value for a state lasting n cycles.
  function automatic logic [CNT_W-1:0] load_for(input int unsigned n);
    if (n == 0) return '0;
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load on state entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// 8080-style parallel bus writer for the ILI9341-class panel: stream
// words onto csx/dcx/d/wrx with strobe timing, and sequence panel reset.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned CS_SETUP_CYCLES  = LCD_CS_SETUP_CYCLES,
  parameter int unsigned WR_LOW_CYCLES    = LCD_WR_LOW_CYCLES,
  parameter int unsigned WR_HIGH_CYCLES   = LCD_WR_HIGH_CYCLES,
  parameter int unsigned RESX_LOW_CYCLES  = LCD_RESX_LOW_CYCLES,
  parameter int unsigned RESX_WAIT_CYCLES = LCD_RESX_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_dcx,
  input  logic        in_last,
  input  logic        hw_reset_req,
  output logic        busy,
  output logic        lcd_csx,
  output logic        lcd_dcx,
  output logic        lcd_wrx,
  output logic        lcd_resx,
  output logic [15:0] lcd_d,
  output logic        lcd_debug
);

  lcd_state_t       state, state_n;
  logic             rst_pend, rst_pend_n;
  logic             last_q;
  logic             csx_n;
  logic             restart;
  logic             accept;
  logic             closing;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  // csx stays low for one IDLE cycle after a last word, then rises.
  assign closing = !lcd_csx && last_q;
  assign accept  = in_valid && in_ready;
  assign busy    = (state != IDLE);

  // Handshake: open in IDLE, or in the final WR_HIGH cycle of a non-last word.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = !rst_pend && !closing;
      WR_HIGH: in_ready = cnt_zero && !last_q && !rst_pend;
      default: in_ready = 1'b0;
    endcase
  end

  // Next state, next csx and pending-reset bookkeeping.
  always_comb begin
    state_n    = state;
    csx_n      = lcd_csx;
    rst_pend_n = rst_pend || hw_reset_req;
    restart    = 1'b0;
    case (state)
      RST_LOW: begin
        rst_pend_n = 1'b0;
        csx_n      = 1'b1;
        if (hw_reset_req) restart = 1'b1;
        else if (cnt_zero) state_n = RST_WAIT;
      end
      RST_WAIT: begin
        rst_pend_n = 1'b0;
        csx_n      = 1'b1;
        if (hw_reset_req) state_n = RST_LOW;
        else if (cnt_zero) state_n = IDLE;
      end
      IDLE: begin
        if (rst_pend) begin
          state_n    = RST_LOW;
          csx_n      = 1'b1;
          rst_pend_n = 1'b0;
        end else if (accept) begin
          state_n = lcd_csx ? SETUP : WR_LOW;
          csx_n   = 1'b0;
        end else if (closing) begin
          csx_n = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_zero) state_n = WR_LOW;
      end
      WR_LOW: begin
        if (cnt_zero) state_n = WR_HIGH;
      end
      WR_HIGH: begin
        if (cnt_zero) begin
          if (last_q && rst_pend) begin
            state_n    = RST_LOW;
            csx_n      = 1'b1;
            rst_pend_n = 1'b0;
          end else if (accept) begin
            state_n = WR_LOW;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = RST_LOW;
    endcase
  end

  // Reload the shared counter on every state entry (and on reset restart).
  always_comb begin
    cnt_load = (state_n != state) || restart;
    case (state_n)
      RST_LOW:  cnt_load_val = load_for(RESX_LOW_CYCLES);
      RST_WAIT: cnt_load_val = load_for(RESX_WAIT_CYCLES);
      SETUP:    cnt_load_val = load_for(CS_SETUP_CYCLES);
      WR_LOW:   cnt_load_val = load_for(WR_LOW_CYCLES);
      WR_HIGH:  cnt_load_val = load_for(WR_HIGH_CYCLES);
      default:  cnt_load_val = '0;
    endcase
  end

  lcd_delay_counter #(
    .RESET_VALUE(load_for(RESX_LOW_CYCLES))
  ) u_delay (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (cnt_load_val),
    .zero       (cnt_zero)
  );

  // State register and pending reset flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RST_LOW;
      rst_pend <= 1'b0;
    end else begin
      state    <= state_n;
      rst_pend <= rst_pend_n;
    end
  end

  // Registered panel controls, decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_csx   <= 1'b1;
      lcd_wrx   <= 1'b1;
      lcd_resx  <= 1'b0;
      lcd_debug <= 1'b1;
    end else begin
      lcd_csx   <= csx_n;
      lcd_wrx   <= (state_n != WR_LOW);
      lcd_resx  <= (state_n != RST_LOW);
      lcd_debug <= (state_n != IDLE);
    end
  end

  // Word capture: d, dcx and last change only on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_d   <= '0;
      lcd_dcx <= 1'b1;
      last_q  <= 1'b0;
    end else if (accept) begin
      lcd_d   <= in_data;
      lcd_dcx <= in_dcx;
      last_q  <= in_last;
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed self-checking bench for lcd_bus_writer with shortened reset timing.
module tb_lcd_bus_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_dcx;
  logic        in_last;
  logic        hw_reset_req;
  logic        busy;
  logic        lcd_csx, lcd_dcx, lcd_wrx, lcd_resx, lcd_debug;
  logic [15:0] lcd_d;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Pixel stream expectations, bit r = relative cycle r.
  logic [19:0] px_wrx_low = 20'h0CCCC;
  logic [19:0] px_csx_low = 20'h7FFFE;
  logic [19:0] px_rdy     = 20'h82221;
  logic [15:0] px [4]     = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};

  always #5 clk = ~clk;

  lcd_bus_writer #(
    .CS_SETUP_CYCLES  (1),
    .WR_LOW_CYCLES    (2),
    .WR_HIGH_CYCLES   (2),
    .RESX_LOW_CYCLES  (4),
    .RESX_WAIT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_dcx       (in_dcx),
    .in_last      (in_last),
    .hw_reset_req (hw_reset_req),
    .busy         (busy),
    .lcd_csx      (lcd_csx),
    .lcd_dcx      (lcd_dcx),
    .lcd_wrx      (lcd_wrx),
    .lcd_resx     (lcd_resx),
    .lcd_d        (lcd_d),
    .lcd_debug    (lcd_debug)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic dcx, input logic last);
    in_valid = v;
    in_data  = d;
    in_dcx   = dcx;
    in_last  = last;
  endtask

  task automatic check_reset_values(input string name);
    check({name, " csx"},   32'(lcd_csx),   32'd1);
    check({name, " dcx"},   32'(lcd_dcx),   32'd1);
    check({name, " wrx"},   32'(lcd_wrx),   32'd1);
    check({name, " resx"},  32'(lcd_resx),  32'd0);
    check({name, " d"},     32'(lcd_d),     32'd0);
    check({name, " rdy"},   32'(in_ready),  32'd0);
    check({name, " busy"},  32'(busy),      32'd1);
    check({name, " debug"}, 32'(lcd_debug), 32'd1);
  endtask

  // Starts in the first cycle after reset_n release; ends in the IDLE cycle.
  task automatic power_up_seq(input string name);
    for (int c = 0; c <= 12; c++) begin
      check($sformatf("%s resx c%0d", name, c), 32'(lcd_resx), 32'(c >= 4));
      check($sformatf("%s rdy c%0d",  name, c), 32'(in_ready), 32'(c == 12));
      check($sformatf("%s csx c%0d",  name, c), 32'(lcd_csx),  32'd1);
      check($sformatf("%s busy c%0d", name, c), 32'(busy),     32'(c < 12));
      if (c < 12) next_cycle();
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    hw_reset_req = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    check_reset_values("por");
    reset_n = 1'b1;
    power_up_seq("pwrup");

    // Single command 0x002C, dcx=0, last=1.
    for (int r = 0; r <= 7; r++) begin
      if (r == 0) drive(1'b1, 16'h002C, 1'b0, 1'b1);
      else        drive(1'b0, 16'h0000, 1'b1, 1'b0);
      check($sformatf("cmd csx r%0d",  r), 32'(lcd_csx),   32'(!(r >= 1 && r <= 6)));
      check($sformatf("cmd wrx r%0d",  r), 32'(lcd_wrx),   32'(!(r == 2 || r == 3)));
      check($sformatf("cmd rdy r%0d",  r), 32'(in_ready),  32'(r == 0 || r == 7));
      check($sformatf("cmd busy r%0d", r), 32'(busy),      32'(r >= 1 && r <= 5));
      check($sformatf("cmd dbg r%0d",  r), 32'(lcd_debug), 32'(r >= 1 && r <= 5));
      if (r >= 1) begin
        check($sformatf("cmd d r%0d",   r), 32'(lcd_d),   32'h002C);
        check($sformatf("cmd dcx r%0d", r), 32'(lcd_dcx), 32'd0);
      end
      if (r < 7) next_cycle();
    end

    // Four-pixel stream, in_valid held high, last on the final word.
    for (int r = 0; r <= 19; r++) begin
      if (r == 0)       drive(1'b1, px[0], 1'b1, 1'b0);
      else if (r <= 5)  drive(1'b1, px[1], 1'b1, 1'b0);
      else if (r <= 9)  drive(1'b1, px[2], 1'b1, 1'b0);
      else if (r <= 13) drive(1'b1, px[3], 1'b1, 1'b1);
      else              drive(1'b0, 16'h0000, 1'b1, 1'b0);
      check($sformatf("px csx r%0d",  r), 32'(lcd_csx),  32'(!px_csx_low[r]));
      check($sformatf("px wrx r%0d",  r), 32'(lcd_wrx),  32'(!px_wrx_low[r]));
      check($sformatf("px rdy r%0d",  r), 32'(in_ready), 32'(px_rdy[r]));
      check($sformatf("px busy r%0d", r), 32'(busy),     32'(r >= 1 && r <= 17));
      if (r >= 1) begin
        check($sformatf("px d r%0d", r), 32'(lcd_d),
              32'((r <= 5) ? px[0] : (r <= 9) ? px[1] : (r <= 13) ? px[2] : px[3]));
        check($sformatf("px dcx r%0d", r), 32'(lcd_dcx), 32'd1);
      end
      if (r < 19) next_cycle();
    end

    // Open transaction paused after two words, resumed without SETUP.
    for (int r = 0; r <= 25; r++) begin
      if (r == 0)       drive(1'b1, 16'h1111, 1'b1, 1'b0);
      else if (r <= 5)  drive(1'b1, 16'h2222, 1'b1, 1'b0);
      else if (r == 19) drive(1'b1, 16'h3333, 1'b1, 1'b1);
      else              drive(1'b0, 16'h0000, 1'b1, 1'b0);
      check($sformatf("gap csx r%0d", r), 32'(lcd_csx), 32'(!(r >= 1 && r <= 24)));
      check($sformatf("gap wrx r%0d", r), 32'(lcd_wrx),
            32'(!(r == 2 || r == 3 || r == 6 || r == 7 || r == 20 || r == 21)));
      check($sformatf("gap rdy r%0d", r), 32'(in_ready),
            32'(r == 0 || r == 5 || (r >= 9 && r <= 19) || r == 25));
      check($sformatf("gap busy r%0d", r), 32'(busy),
            32'((r >= 1 && r <= 9) || (r >= 20 && r <= 23)));
      if (r >= 1) begin
        check($sformatf("gap d r%0d", r), 32'(lcd_d),
              32'((r <= 5) ? 16'h1111 : (r <= 19) ? 16'h2222 : 16'h3333));
      end
      if (r < 25) next_cycle();
    end

    // hw_reset_req during WR_LOW of a last word: write finishes, then reset.
    for (int r = 0; r <= 18; r++) begin
      if (r == 0) drive(1'b1, 16'h0029, 1'b0, 1'b1);
      else        drive(1'b0, 16'h0000, 1'b1, 1'b0);
      hw_reset_req = (r == 2);
      check($sformatf("hwr csx r%0d",  r), 32'(lcd_csx),  32'(!(r >= 1 && r <= 5)));
      check($sformatf("hwr wrx r%0d",  r), 32'(lcd_wrx),  32'(!(r == 2 || r == 3)));
      check($sformatf("hwr resx r%0d", r), 32'(lcd_resx), 32'(!(r >= 6 && r <= 9)));
      check($sformatf("hwr rdy r%0d",  r), 32'(in_ready), 32'(r == 0 || r == 18));
      check($sformatf("hwr busy r%0d", r), 32'(busy),     32'(r >= 1 && r <= 17));
      if (r < 18) next_cycle();
    end
    hw_reset_req = 1'b0;

    // reset_n asserted during WR_LOW: immediate return to reset values.
    for (int r = 0; r <= 2; r++) begin
      if (r == 0) drive(1'b1, 16'hABCD, 1'b1, 1'b0);
      else        drive(1'b0, 16'h0000, 1'b1, 1'b0);
      if (r < 2) next_cycle();
    end
    check("mid wrx before", 32'(lcd_wrx), 32'd0);
    check("mid csx before", 32'(lcd_csx), 32'd0);
    check("mid d before",   32'(lcd_d),   32'hABCD);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid");
    next_cycle();
    reset_n = 1'b1;
    power_up_seq("rerun");
    check("rerun d lost", 32'(lcd_d), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
